sat_gain_pipe: RTL
==================

SAT_GAIN_PIPE -- requirements
Module: sat_gain_pipe

Interface
REQ-001 Parameter W, default 8, data width in bits (>=2).
REQ-002 Parameter GW, default 4, gain width in bits (>=1).
REQ-003 Parameter STAGES, default 2, pipeline depth in register stages (>=1).
REQ-004 Parameter CNT_W, default 16, saturation counter width.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  upstream data valid.
REQ-008 in_ready  output  1  block can accept a beat this cycle.
REQ-009 in_data  input  W  unsigned operand.
REQ-010 in_gain  input  GW  unsigned gain, sampled with in_data on the same beat.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_data  output  W  saturated product.
REQ-014 out_sat  output  1  result for this beat was clamped.
REQ-015 clr_count  input  1  synchronous clear of sat_count.
REQ-016 sat_count  output  CNT_W  number of saturated beats delivered.

Function
REQ-017 The block SHALL transfer an input beat when in_valid && in_ready, and an output beat when out_valid && out_ready.
REQ-018 The product SHALL be computed at full width W+GW as in_data*in_gain, unsigned.
REQ-019 When the product exceeds 2^W-1, out_data SHALL be 2^W-1 with out_sat=1; otherwise out_data is the product and out_sat=0.
REQ-020 With out_ready held high, a beat accepted in cycle N SHALL appear on out_valid/out_data in cycle N+STAGES; throughput one beat per cycle.
REQ-021 Each stage SHALL load when it is empty or its contents advance in the same cycle; in_ready SHALL equal stage-1 load permission.
REQ-022 Under backpressure the pipeline SHALL hold up to STAGES beats without loss, duplication or reordering; bubbles SHALL collapse.
REQ-023 out_data and out_sat SHALL be 0 whenever out_valid=0.
REQ-024 out_valid, once asserted, SHALL remain asserted with stable out_data/out_sat until the transfer occurs.
REQ-025 sat_count SHALL increment by 1 on each output transfer with out_sat=1 and SHALL hold at 2^CNT_W-1 (no wrap).
REQ-026 clr_count SHALL set sat_count to 0 next cycle, taking priority over a simultaneous increment.

Reset
REQ-027 While rst_n=0: out_valid=0, out_data=0, out_sat=0, sat_count=0, all stages empty; in_ready=1 from the first cycle after release.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight beats; no beat accepted before reset SHALL emerge after it.

Structure
REQ-029 Package sat_gain_pkg SHALL hold the default parameter constants and the stage payload typedef (data, sat flag).
REQ-030 One sub-module sat_gain_stage SHALL implement a single valid/ready register stage, instantiated STAGES times; multiply-and-clamp logic sits before stage 1.

Verification (W=8, GW=4, STAGES=2)
REQ-031 data=10, gain=3, out_ready=1 -> out_data=30, out_sat=0, exactly 2 cycles later.
REQ-032 data=127, gain=2 -> 254, sat=0; data=128, gain=2 -> 255, sat=1; data=17, gain=15 -> 255, sat=0.
REQ-033 Continuous input 1..8 (gain=1) with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted; on release, outputs 1..8 in order, none lost.
REQ-034 Three saturating beats delivered -> sat_count=3; clr_count together with a 4th saturating transfer -> sat_count=0.
REQ-035 rst_n pulsed low with 2 beats in flight -> out_valid=0 and sat_count=0 immediately; neither beat appears after release.

Source files
------------

// File: rtl/sat_gain_pkg.sv
// Shared constants and payload type for the saturating gain pipeline.
// Holds the default parameter values and the per-stage payload layout
// (clamped data plus saturation flag) at the default data width.
package sat_gain_pkg;

   localparam int DEF_W      = 8;
   localparam int DEF_GW     = 4;
   localparam int DEF_STAGES = 2;
   localparam int DEF_CNT_W  = 16;

   typedef struct packed {
      logic [DEF_W-1:0] data;
      logic             sat;
   } beat_t;

endpackage

// File: rtl/sat_gain_stage.sv
// Single valid/ready register stage.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   up_valid/up_ready   upstream handshake, up_data payload in
//   dn_valid/dn_ready   downstream handshake, dn_data payload out
// The stage loads whenever it is empty or its current beat leaves this
// cycle, so bubbles collapse and a full pipe still streams one beat/cycle.
module sat_gain_stage
   import sat_gain_pkg::*;
#(
   parameter int P = $bits(beat_t)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [P-1:0] up_data,
   output logic         dn_valid,
   input  logic         dn_ready,
   output logic [P-1:0] dn_data
);

   logic         full;
   logic [P-1:0] data_q;

   assign up_ready = !full || dn_ready;
   assign dn_valid = full;
   assign dn_data  = data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full   <= 1'b0;
         data_q <= '0;
      end else if (up_ready) begin
         full <= up_valid;
         if (up_valid) begin
            data_q <= up_data;
         end
      end
   end

endmodule

// File: rtl/sat_gain_pipe.sv
// Unsigned multiply-by-gain with clamp to the data range, followed by a
// STAGES-deep valid/ready pipeline and a saturating count of clamped beats.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake; in_data and in_gain sampled together
//   out_valid/out_ready   output handshake; out_data/out_sat are 0 when idle
//   clr_count             synchronous clear of sat_count (wins over increment)
//   sat_count             delivered clamped beats, sticks at all-ones
module sat_gain_pipe
   import sat_gain_pkg::*;
#(
   parameter int W      = DEF_W,
   parameter int GW     = DEF_GW,
   parameter int STAGES = DEF_STAGES,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic [GW-1:0]    in_gain,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             out_sat,
   input  logic             clr_count,
   output logic [CNT_W-1:0] sat_count
);

   typedef struct packed {
      logic [W-1:0] data;
      logic         sat;
   } beat_w_t;

   localparam int BW = $bits(beat_w_t);

   logic [W+GW-1:0] product;
   beat_w_t         in_beat;

   always_comb begin
      product      = {{GW{1'b0}}, in_data} * {{W{1'b0}}, in_gain};
      in_beat.sat  = |product[W+GW-1:W];
      in_beat.data = in_beat.sat ? {W{1'b1}} : product[W-1:0];
   end

   // Index 0 is the clamp logic's output, index STAGES the block output.
   logic [STAGES:0] chain_valid;
   logic [STAGES:0] chain_ready;
   beat_w_t         chain_data [STAGES+1];

   assign chain_valid[0]      = in_valid;
   assign chain_data[0]       = in_beat;
   assign in_ready            = chain_ready[0];
   assign chain_ready[STAGES] = out_ready;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      sat_gain_stage #(.P(BW)) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .up_valid (chain_valid[i]),
         .up_ready (chain_ready[i]),
         .up_data  (chain_data[i]),
         .dn_valid (chain_valid[i+1]),
         .dn_ready (chain_ready[i+1]),
         .dn_data  (chain_data[i+1])
      );
   end

   // Stage registers keep stale payload after a beat leaves; mask it here.
   assign out_valid = chain_valid[STAGES];
   assign out_data  = out_valid ? chain_data[STAGES].data : '0;
   assign out_sat   = out_valid & chain_data[STAGES].sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= '0;
      end else if (clr_count) begin
         sat_count <= '0;
      end else if (out_valid && out_ready && out_sat && (sat_count != {CNT_W{1'b1}})) begin
         sat_count <= sat_count + CNT_W'(1);
      end
   end

endmodule
